// File: rtl/bus_xfer_queue.sv
// Request queue that turns byte-addressed requests into lane-aligned bus beats (mask/data/err computed at push).
// Latency 1 (no bypass when empty); req_ready_o drops only when full and never depends on out_ready_i.
module bus_xfer_queue #(
  parameter  int AW    = 32,
  parameter  int DW    = 32,
  parameter  int AIW   = 8,
  parameter  int DUW   = 16,
  parameter  int Depth = 4,
  localparam int DBW   = DW / 8,
  localparam int SZW   = $clog2($clog2(DBW) + 1),
  localparam int LW    = $clog2(Depth + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic [AW-1:0]  req_addr_i,
  input  logic           req_we_i,
  input  logic [SZW-1:0] req_size_i,
  input  logic [DW-1:0]  req_wdata_i,
  input  logic [AIW-1:0] req_source_i,
  input  logic [DUW-1:0] req_user_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [AW-1:0]  out_addr_o,
  output logic           out_we_o,
  output logic [DBW-1:0] out_mask_o,
  output logic [DW-1:0]  out_wdata_o,
  output logic [AIW-1:0] out_source_o,
  output logic [DUW-1:0] out_user_o,
  output logic           out_err_o,
  output logic [LW-1:0]  level_o
);
  localparam int OB = $clog2(DBW);
  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic           we;
    logic [DBW-1:0] mask;
    logic [DW-1:0]  wdata;
    logic [AIW-1:0] source;
    logic [DUW-1:0] user;
    logic           err;
  } entry_t;

  entry_t          mem [Depth];
  entry_t          push_ent;
  entry_t          head;
  logic [PW-1:0]   wptr, rptr;
  logic [LW-1:0]   level;
  logic            run;
  logic            push, pop;
  logic            err_c;
  int              off, nbytes;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  // run holds ready low throughout reset and rises on the first edge after release.
  assign req_ready_o = run && (level != LW'(Depth));
  assign out_valid_o = (level != '0);
  assign push        = req_valid_i && req_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign level_o     = level;

  always_comb begin
    off    = int'(req_addr_i[OB-1:0]);
    nbytes = 1 << int'(req_size_i);
    err_c  = (int'(req_size_i) > OB) || ((off & (nbytes - 1)) != 0);
    push_ent        = '0;
    push_ent.addr   = {req_addr_i[AW-1:OB], {OB{1'b0}}};
    push_ent.we     = req_we_i;
    push_ent.source = req_source_i;
    push_ent.user   = req_user_i;
    push_ent.err    = err_c;
    for (int i = 0; i < DBW; i++) begin
      push_ent.mask[i] = !err_c && (i >= off) && (i < off + nbytes);
    end
    // Reads still carry the lane mask but never data.
    push_ent.wdata = (err_c || !req_we_i) ? '0 : req_wdata_i << (8 * off);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      if (push && !pop)      level <= level + LW'(1);
      else if (!push && pop) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= push_ent;
  end

  assign head         = mem[rptr];
  assign out_addr_o   = head.addr;
  assign out_we_o     = head.we;
  assign out_mask_o   = head.mask;
  assign out_wdata_o  = head.wdata;
  assign out_source_o = head.source;
  assign out_user_o   = head.user;
  assign out_err_o    = head.err;
endmodule

// File: tb/tb_bus_xfer_queue.sv
// Scoreboard bench: one Depth=4 and one Depth=3 queue share request fields, each with its own valid.
module tb_bus_xfer_queue;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] req_addr, req_wdata;
  logic        req_we;
  logic [1:0]  req_size;
  logic [7:0]  req_source;
  logic [15:0] req_user;
  logic        valid4, valid3, ready4, ready3, out_ready;

  logic        o4_valid, o4_we, o4_err;
  logic [31:0] o4_addr, o4_wdata;
  logic [3:0]  o4_mask;
  logic [7:0]  o4_source;
  logic [15:0] o4_user;
  logic [2:0]  level4;

  logic        o3_valid, o3_we, o3_err;
  logic [31:0] o3_addr, o3_wdata;
  logic [3:0]  o3_mask;
  logic [7:0]  o3_source;
  logic [15:0] o3_user;
  logic [1:0]  level3;

  bus_xfer_queue #(.Depth(4)) u_d4 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(valid4), .req_ready_o(ready4),
    .req_addr_i(req_addr), .req_we_i(req_we), .req_size_i(req_size),
    .req_wdata_i(req_wdata), .req_source_i(req_source), .req_user_i(req_user),
    .out_valid_o(o4_valid), .out_ready_i(out_ready),
    .out_addr_o(o4_addr), .out_we_o(o4_we), .out_mask_o(o4_mask),
    .out_wdata_o(o4_wdata), .out_source_o(o4_source), .out_user_o(o4_user),
    .out_err_o(o4_err), .level_o(level4)
  );

  bus_xfer_queue #(.Depth(3)) u_d3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(valid3), .req_ready_o(ready3),
    .req_addr_i(req_addr), .req_we_i(req_we), .req_size_i(req_size),
    .req_wdata_i(req_wdata), .req_source_i(req_source), .req_user_i(req_user),
    .out_valid_o(o3_valid), .out_ready_i(out_ready),
    .out_addr_o(o3_addr), .out_we_o(o3_we), .out_mask_o(o3_mask),
    .out_wdata_o(o3_wdata), .out_source_o(o3_source), .out_user_o(o3_user),
    .out_err_o(o3_err), .level_o(level3)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [7:0]  source;
    logic [15:0] user;
    logic        err;
  } beat_t;

  beat_t exp4[$];
  beat_t exp3[$];
  int applied = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon4
    beat_t a;
    a = '{addr: o4_addr, we: o4_we, mask: o4_mask, wdata: o4_wdata,
          source: o4_source, user: o4_user, err: o4_err};
    if (rst_n && o4_valid && out_ready) begin
      if (exp4.size() == 0) begin
        applied++; miscompares++;
        $display("FAIL d4_unexpected_beat: got %h expected none", a);
      end else chk("d4_beat", 128'(a), 128'(exp4.pop_front()));
    end
  end

  always @(negedge clk) begin : mon3
    beat_t a;
    a = '{addr: o3_addr, we: o3_we, mask: o3_mask, wdata: o3_wdata,
          source: o3_source, user: o3_user, err: o3_err};
    if (rst_n && o3_valid && out_ready) begin
      if (exp3.size() == 0) begin
        applied++; miscompares++;
        $display("FAIL d3_unexpected_beat: got %h expected none", a);
      end else chk("d3_beat", 128'(a), 128'(exp3.pop_front()));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int which, input logic [31:0] addr, input logic we,
                      input logic [1:0] size, input logic [31:0] wdata,
                      input logic [7:0] src, input logic [15:0] user,
                      input logic [31:0] e_addr, input logic [3:0] e_mask,
                      input logic [31:0] e_wdata, input logic e_err);
    beat_t e;
    bit    done;
    done = 1'b0;
    e = '{addr: e_addr, we: we, mask: e_mask, wdata: e_wdata, source: src, user: user, err: e_err};
    req_addr = addr; req_we = we; req_size = size; req_wdata = wdata;
    req_source = src; req_user = user;
    if (which == 0) valid4 = 1'b1; else valid3 = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      if ((which == 0) ? ready4 : ready3) begin
        if (which == 0) exp4.push_back(e); else exp3.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    valid4 = 1'b0; valid3 = 1'b0;
    applied++;
    if (!done) begin
      miscompares++;
      $display("FAIL accept_timeout: src %h never accepted, required acceptance", src);
    end
  endtask

  task automatic fill(input int which, input int k);
    send(which, 32'(k * 4), 1'b1, 2'd2, 32'(k), 8'(k + 16), 16'(k + 256),
         32'(k * 4), 4'hF, 32'(k), 1'b0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 100 && (exp4.size() + exp3.size()) != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("drain_left", 128'(exp4.size() + exp3.size()), 128'(0));
  endtask

  initial begin
    rst_n = 1'b0; valid4 = 1'b0; valid3 = 1'b0; out_ready = 1'b0;
    req_addr = '0; req_we = 1'b0; req_size = '0; req_wdata = '0;
    req_source = '0; req_user = '0;
    #12;
    chk("rst_ready", {ready4, ready3}, 2'b00);
    chk("rst_valid", {o4_valid, o3_valid}, 2'b00);
    chk("rst_level", {level4, level3}, 5'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {ready4, ready3}, 2'b11);

    // Alignment vectors: addr, we, size, wdata, src, user -> addr, mask, wdata, err
    out_ready = 1'b1;
    send(0, 32'h1003, 1, 0, 32'h000000A5, 8'h01, 16'h1111, 32'h1000, 4'b1000, 32'hA5000000, 0);
    send(0, 32'h2002, 1, 1, 32'h0000BEEF, 8'h02, 16'h2222, 32'h2000, 4'b1100, 32'hBEEF0000, 0);
    send(0, 32'h2001, 1, 1, 32'h00001234, 8'h03, 16'h3333, 32'h2000, 4'b0000, 32'h00000000, 1);
    send(0, 32'h3000, 1, 3, 32'h0000FFFF, 8'h04, 16'h4444, 32'h3000, 4'b0000, 32'h00000000, 1);
    send(0, 32'h4004, 0, 2, 32'hDEADBEEF, 8'h05, 16'h5555, 32'h4004, 4'b1111, 32'h00000000, 0);
    send(0, 32'h5001, 1, 0, 32'h12345678, 8'h06, 16'h6666, 32'h5000, 4'b0010, 32'h34567800, 0);
    send(0, 32'h6000, 1, 2, 32'hCAFEF00D, 8'h07, 16'h7777, 32'h6000, 4'b1111, 32'hCAFEF00D, 0);
    send(0, 32'h6002, 1, 2, 32'hCAFEF00D, 8'h08, 16'h8888, 32'h6000, 4'b0000, 32'h00000000, 1);
    send(3, 32'h7006, 1, 1, 32'h0000ABCD, 8'h09, 16'h9999, 32'h7004, 4'b1100, 32'hABCD0000, 0);
    send(3, 32'h7003, 0, 0, 32'hFFFFFFFF, 8'h0A, 16'hAAAA, 32'h7000, 4'b1000, 32'h00000000, 0);
    drain();

    // Fill Depth=4, check full, then stream with simultaneous push/pop.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) fill(0, k);
    repeat (2) @(posedge clk); #1;
    chk("d4_full_level", 128'(level4), 128'(4));
    chk("d4_full_ready", 128'(ready4), 128'(0));
    chk("d4_hold_head", {o4_valid, o4_source, o4_addr}, {1'b1, 8'h10, 32'h0});
    out_ready = 1'b1;
    for (int k = 4; k < 14; k++) fill(0, k);
    chk("d4_stream_level", 128'(level4), 128'(3));
    drain();

    // Same on Depth=3 to exercise non-power-of-2 pointer wrap.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) fill(3, k);
    #1;
    chk("d3_full_level", 128'(level3), 128'(3));
    chk("d3_full_ready", 128'(ready3), 128'(0));
    out_ready = 1'b1;
    for (int k = 3; k < 13; k++) fill(3, k);
    drain();

    // Reset with entries queued.
    out_ready = 1'b0;
    for (int k = 20; k < 23; k++) fill(0, k);
    chk("pre_rst_level", 128'(level4), 128'(3));
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 128'(o4_valid), 128'(0));
    chk("midrst_level", 128'(level4), 128'(0));
    chk("midrst_ready", 128'(ready4), 128'(0));
    exp4.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 128'(ready4), 128'(1));
    send(0, 32'h8001, 1, 0, 32'h0000005A, 8'h30, 16'hBEAD, 32'h8000, 4'b0010, 32'h00005A00, 0);
    chk("post_rst_present", {o4_valid, level4}, {1'b1, 3'd1});
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/bus_xfer_queue.md
BUS_XFER_QUEUE -- requirements
Module: bus_xfer_queue

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning bus address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning bus data width; it must be a multiple of 8 and at least 16.
REQ-003 The block SHALL have parameter AIW, default 8, meaning source ID width.
REQ-004 The block SHALL have parameter DUW, default 16, meaning data user width.
REQ-005 The block SHALL have parameter Depth, default 4, meaning queue entries; it must be at least 1.
REQ-006 The block SHALL use derived local values DBW = DW/8 and SZW = $clog2($clog2(DBW)+1).
REQ-007 The block SHALL have a single clock and an asynchronous, active-low reset, with the following ports.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high with valid
- req_addr_i  in  AW  byte address
- req_we_i  in  1  write enable
- req_size_i  in  SZW  log2 of transfer bytes
- req_wdata_i  in  DW  write data, LSB-justified
- req_source_i  in  AIW  source ID
- req_user_i  in  DUW  user bits
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  downstream accepts
- out_addr_o  out  AW  address with low $clog2(DBW) bits zeroed
- out_we_o  out  1  write enable
- out_mask_o  out  DBW  byte-lane mask
- out_wdata_o  out  DW  write data placed in lanes
- out_source_o  out  AIW  source ID
- out_user_o  out  DUW  user bits
- out_err_o  out  1  request illegal
- level_o  out  $clog2(Depth+1)  occupied entries

Function
REQ-008 A request SHALL be pushed when req_valid_i && req_ready_o, and an entry SHALL be popped when out_valid_o && out_ready_i.
REQ-009 req_ready_o SHALL equal (level_o != Depth); it SHALL be registered-state-derived, with no combinational path from out_ready_i.
REQ-010 out_valid_o SHALL equal (level_o != 0); a request pushed in cycle N SHALL first be presented in cycle N+1 (latency 1), and all out_* fields SHALL be driven from storage.
REQ-011 The queue SHALL be FIFO ordered; read and write pointers SHALL wrap modulo Depth, including when Depth is not a power of 2.
REQ-012 On a simultaneous push and pop, level_o SHALL be unchanged, both pointers SHALL advance, and this SHALL be legal at level 0 < L < Depth.
REQ-013 At level 0 a push SHALL NOT bypass to the output; at level Depth no push SHALL occur, while a pop remains allowed.
REQ-014 Let off = addr[$clog2(DBW)-1:0] and bytes = 2^size. out_mask_o SHALL be ((1<<bytes)-1) << off, truncated to DBW.
REQ-015 out_wdata_o SHALL be req_wdata_i << (8*off), truncated to DW.
REQ-016 A request is illegal when size > $clog2(DBW) or off is not a multiple of bytes.
REQ-017 An illegal request SHALL still be queued, with out_err_o=1, out_mask_o=0, and out_wdata_o=0; all other fields SHALL pass unchanged.
REQ-018 Mask, data and error SHALL be computed at push time and stored; the stored values SHALL be independent of later input changes.
REQ-019 Entries for read requests (req_we_i=0) SHALL carry the computed mask, and out_wdata_o SHALL be 0.
REQ-020 While out_valid_o=1 and out_ready_i=0, all out_* outputs SHALL hold stable.

Reset
REQ-021 On rst_ni low, asynchronously, pointers and level SHALL clear, and the block SHALL drive out_valid_o=0, req_ready_o=0 during reset, and level_o=0.
REQ-022 After reset deasserts, req_ready_o SHALL be 1 on the first clock edge.
REQ-023 A reset mid-operation SHALL discard all queued entries, and no partial pop SHALL be reported.
REQ-024 Storage data SHALL NOT need reset; out_* data fields SHALL NOT be checked while out_valid_o=0.

Verification
REQ-025 Byte write (DW=32): addr=0x1003, size=0, wdata=0xA5 -> next cycle out_addr_o=0x1000, mask=4'b1000, wdata=0xA5000000, err=0.
REQ-026 Half write: addr=0x2002, size=1, wdata=0xBEEF -> mask=4'b1100, wdata=0xBEEF0000.
REQ-027 Misaligned write: addr=0x2001, size=1 -> err=1, mask=0, wdata=0.
REQ-028 Oversize write: size=3 with DW=32 -> err=1.
REQ-029 Fill: push 4 requests with out_ready_i=0 -> level_o=4 and req_ready_o=0; then push and pop together for 10 cycles -> source IDs emerge in order with no loss; run with Depth=3 to check wrap.
REQ-030 Reset with 3 entries queued -> out_valid_o=0 and level_o=0 immediately; the next push is presented after 1 cycle.
